// File: rtl/tiny16_bus_pkg.sv
// Shared types and timing helpers for the tiny16 system bus initiator.
package tiny16_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_t;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;

    // The counter is loaded with N-1, so it must hold values up to max(N)-1.
    function automatic int phase_cnt_width(input int setup_c, input int strobe_c, input int hold_c);
        int m;
        m = setup_c;
        if (strobe_c > m) m = strobe_c;
        if (hold_c > m) m = hold_c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter that times each bus phase; stops at zero and can be frozen.
module bus_phase_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!hold && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_initiator.sv
// tiny16 bus master: turns single-beat valid/ready commands into nrd/nwr strobe cycles.
// Define BUS_WAIT_EN to add the active-low nwait input that stretches the strobe.
module bus_initiator
    import tiny16_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
`ifdef BUS_WAIT_EN
    input  logic                  nwait,
`endif
    output logic                  nrd,
    output logic                  nwr
);

    localparam int CW = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    bus_state_t            state_q, state_d;
    logic                  phase_zero, load, strobe_wait, write_q;
    logic [CW-1:0]         load_value;
    logic                  nrd_d, nwr_d, rsp_valid_d, rsp_write_d, write_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0] data_out_d, rsp_rdata_d;

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high exactly while the FSM is in IDLE and reset is released.
    assign cmd_ready = nreset && (state_q == IDLE);
    assign busy      = (state_q != IDLE);

`ifdef BUS_WAIT_EN
    assign strobe_wait = (state_q == STROBE) && phase_zero && !nwait;
`else
    assign strobe_wait = 1'b0;
`endif

    bus_phase_timer #(.WIDTH(CW)) u_timer (
        .clk        (clk),
        .nreset     (nreset),
        .load       (load),
        .load_value (load_value),
        .hold       (strobe_wait),
        .zero       (phase_zero)
    );

    always_ff @(posedge clk) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_value = '0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d    = SETUP;
                load       = 1'b1;
                load_value = SETUP_LOAD;
            end
            SETUP: if (phase_zero) begin
                state_d    = STROBE;
                load       = 1'b1;
                load_value = STROBE_LOAD;
            end
            STROBE: if (phase_zero && !strobe_wait) begin
                if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d    = HOLD;
                    load       = 1'b1;
                    load_value = HOLD_LOAD;
                end
            end
            HOLD: if (phase_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        address_d   = address;
        data_out_d  = data_out;
        write_d     = write_q;
        nrd_d       = nrd;
        nwr_d       = nwr;
        rsp_rdata_d = rsp_rdata;
        rsp_write_d = rsp_write;
        // Completion is flagged on the edge that returns the FSM to IDLE.
        rsp_valid_d = (state_q != IDLE) && (state_d == IDLE);
        if (rsp_valid_d) rsp_write_d = write_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                address_d = cmd_address;
                write_d   = cmd_write;
                if (cmd_write) data_out_d = cmd_wdata;
            end
            SETUP: if (phase_zero) begin
                nrd_d = write_q;
                nwr_d = !write_q;
            end
            STROBE: if (phase_zero && !strobe_wait) begin
                nrd_d = 1'b1;
                nwr_d = 1'b1;
                if (!write_q) rsp_rdata_d = data_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            nrd       <= 1'b1;
            nwr       <= 1'b1;
            address   <= '0;
            data_out  <= '0;
            write_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            nrd       <= nrd_d;
            nwr       <= nwr_d;
            address   <= address_d;
            data_out  <= data_out_d;
            write_q   <= write_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: default-timing instance u0 and a SETUP=2/STROBE=1/HOLD=0 instance u1.
module tb_bus_initiator;

    logic        clk = 1'b0;
    logic        nreset;
    logic        nwait;
    logic        led;
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic        cmd_write   [2];
    logic [15:0] cmd_address [2];
    logic [15:0] cmd_wdata   [2];
    logic        rsp_valid   [2];
    logic        rsp_write   [2];
    logic [15:0] rsp_rdata   [2];
    logic        busy        [2];
    logic [15:0] address     [2];
    logic [15:0] data_out    [2];
    logic [15:0] data_in     [2];
    logic        nrd         [2];
    logic        nwr         [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0] ^ 8'h5A;
        return (a == 16'h0003) ? 16'hA55A : {lo, a[15:8]};
    endfunction

    function automatic int s_of(input int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int t_of(input int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int h_of(input int k); return (k == 0) ? 1 : 0; endfunction

    // ROM responder drives garbage unless the read strobe is low and nothing is waiting.
    assign data_in[0] = (!nrd[0] && nwait) ? rom_f(address[0]) : 16'hDEAD;
    assign data_in[1] = (!nrd[1]) ? rom_f(address[1]) : 16'hDEAD;

    always @(negedge nwr[0]) if (address[0] == 16'hC000) led = data_out[0][0];

    bus_initiator u0 (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
        .cmd_address(cmd_address[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0]),
        .busy(busy[0]), .address(address[0]), .data_out(data_out[0]), .data_in(data_in[0]),
`ifdef BUS_WAIT_EN
        .nwait(nwait),
`endif
        .nrd(nrd[0]), .nwr(nwr[0])
    );

    bus_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(0)) u1 (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
        .cmd_address(cmd_address[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1]),
        .busy(busy[1]), .address(address[1]), .data_out(data_out[1]), .data_in(data_in[1]),
`ifdef BUS_WAIT_EN
        .nwait(1'b1),
`endif
        .nrd(nrd[1]), .nwr(nwr[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: each transaction is an accept edge plus a strobe-end edge;
    // every output follows from the edge offsets relative to those two numbers.
    int          edge_n = 0;
    bit          model_on = 0;
    bit          act   [2];
    int          acc   [2];
    int          send  [2];
    logic        m_wr  [2];
    logic [15:0] m_addr[2];
    logic [15:0] e_addr[2];
    logic [15:0] e_dout[2];
    logic [15:0] e_rdata[2];
    logic        e_rw  [2];

    task automatic model_step();
        logic nw;
        edge_n++;
        model_on = 1;
        for (int k = 0; k < 2; k++) begin
            if (!nreset) begin
                act[k] = 0; e_addr[k] = '0; e_dout[k] = '0; e_rdata[k] = '0; e_rw[k] = 1'b0;
            end else begin
                nw = (k == 0) ? nwait : 1'b1;
                if (act[k] && edge_n == send[k]) begin
                    if (!nw) send[k]++;
                    else if (!m_wr[k]) e_rdata[k] = rom_f(m_addr[k]);
                end
                if (act[k] && edge_n == send[k] + h_of(k)) e_rw[k] = m_wr[k];
                if ((!act[k] || edge_n > send[k] + h_of(k)) && cmd_valid[k]) begin
                    act[k]    = 1;
                    acc[k]    = edge_n;
                    send[k]   = edge_n + s_of(k) + t_of(k);
                    m_wr[k]   = cmd_write[k];
                    m_addr[k] = cmd_address[k];
                    e_addr[k] = cmd_address[k];
                    if (cmd_write[k]) e_dout[k] = cmd_wdata[k];
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    logic x_busy, x_low, x_rsp;

    always @(negedge clk) begin
        #2;
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                x_busy = act[k] && edge_n < send[k] + h_of(k);
                x_low  = act[k] && edge_n >= acc[k] + s_of(k) && edge_n < send[k];
                x_rsp  = act[k] && edge_n == send[k] + h_of(k);
                check($sformatf("u%0d.busy", k), busy[k], x_busy);
                check($sformatf("u%0d.cmd_ready", k), cmd_ready[k], nreset && !x_busy);
                check($sformatf("u%0d.nrd", k), nrd[k], !(x_low && !m_wr[k]));
                check($sformatf("u%0d.nwr", k), nwr[k], !(x_low && m_wr[k]));
                check($sformatf("u%0d.strobe_overlap", k), nrd[k] | nwr[k], 1);
                check($sformatf("u%0d.rsp_valid", k), rsp_valid[k], x_rsp);
                check($sformatf("u%0d.rsp_write", k), rsp_write[k], e_rw[k]);
                check($sformatf("u%0d.rsp_rdata", k), rsp_rdata[k], e_rdata[k]);
                check($sformatf("u%0d.address", k), address[k], e_addr[k]);
                check($sformatf("u%0d.data_out", k), data_out[k], e_dout[k]);
            end
        end
    end

    task automatic run_cmd(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input int wait_len, output int lat, output int lows, output int first_low,
                           output logic [15:0] rd, output logic rw);
        int n;
        logic low;
        @(negedge clk);
        cmd_write[k] = wr; cmd_address[k] = a; cmd_wdata[k] = d; cmd_valid[k] = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready[k] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("accept_timeout", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        lat = 0; lows = 0; first_low = -1;
        while (lat < 50) begin
            nwait = !(k == 0 && wait_len > 0 && lat >= s_of(k) + t_of(k) - 1
                      && lat < s_of(k) + t_of(k) - 1 + wait_len);
            #1;
            if (rsp_valid[k]) break;
            low = wr ? !nwr[k] : !nrd[k];
            if (low) begin
                lows++;
                if (first_low < 0) first_low = lat;
            end
            @(negedge clk);
            lat++;
        end
        nwait = 1'b1;
        rd = rsp_rdata[k];
        rw = rsp_write[k];
    endtask

    int          lat, lows, fl, c, acc2, nrsp, nbusy, rsp2_c;
    logic [15:0] rd;
    logic        rw;
    int          vk [7];
    logic        vw [7];
    logic [15:0] va [7];
    logic [15:0] vd [7];
    logic [15:0] vexp [7];

    initial begin
        nreset = 1'b0; nwait = 1'b1; led = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0; cmd_address[k] = '0; cmd_wdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset_nrd", nrd[0], 1);
        check("reset_nwr", nwr[0], 1);
        check("reset_busy", busy[0], 0);
        check("reset_ready", cmd_ready[0], 0);
        check("reset_address", address[0], 16'h0000);
        nreset = 1'b1;
        #1;
        check("ready_after_reset", cmd_ready[0], 1);

        run_cmd(0, 1'b0, 16'h0003, 16'h0000, 0, lat, lows, fl, rd, rw);
        check("rd_latency", lat, 4);
        check("rd_nrd_low_cycles", lows, 2);
        check("rd_nrd_first_low", fl, 1);
        check("rd_rdata", rd, 16'hA55A);
        check("rd_rsp_write", rw, 0);

        run_cmd(0, 1'b1, 16'hC000, 16'h0001, 0, lat, lows, fl, rd, rw);
        check("wr_latency", lat, 4);
        check("wr_nwr_low_cycles", lows, 2);
        check("wr_nwr_first_low", fl, 1);
        check("wr_led", led, 1);
        check("wr_rsp_write", rw, 1);
        check("wr_rdata_kept", rd, 16'hA55A);

        run_cmd(1, 1'b0, 16'h0010, 16'h0000, 0, lat, lows, fl, rd, rw);
        check("u1_rd_latency", lat, 3);
        check("u1_rd_low_cycles", lows, 1);
        check("u1_rd_first_low", fl, 2);
        check("u1_rd_rdata", rd, 16'h4A00);

        vk = '{0, 0, 0, 0, 1, 1, 1};
        vw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        va = '{16'h1234, 16'h2000, 16'h00FF, 16'hC000, 16'h8001, 16'h4000, 16'h1234};
        vd = '{16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'h0000};
        vexp = '{16'h6E12, 16'hBEEF, 16'hA500, 16'h0000, 16'h5B80, 16'h1111, 16'h6E12};
        for (int i = 0; i < 7; i++) begin
            run_cmd(vk[i], vw[i], va[i], vd[i], 0, lat, lows, fl, rd, rw);
            check($sformatf("vec%0d_latency", i), lat, (vk[i] == 0) ? 4 : 3);
            check($sformatf("vec%0d_rsp_write", i), rw, vw[i]);
            if (vw[i]) check($sformatf("vec%0d_data_out", i), data_out[vk[i]], vexp[i]);
            else       check($sformatf("vec%0d_rdata", i), rd, vexp[i]);
        end
        check("led_cleared", led, 0);

        // Back-to-back: read then write with cmd_valid held high throughout.
        @(negedge clk);
        cmd_write[0] = 1'b0; cmd_address[0] = 16'h0003; cmd_valid[0] = 1'b1;
        #1;
        check("b2b_ready", cmd_ready[0], 1);
        @(posedge clk);
        @(negedge clk);
        cmd_write[0] = 1'b1; cmd_address[0] = 16'hC000; cmd_wdata[0] = 16'h0001;
        c = 0; acc2 = -1; nrsp = 0; nbusy = 0; rsp2_c = -1;
        while (c < 60) begin
            #1;
            if (rsp_valid[0]) nrsp++;
            if (nrsp == 2) begin
                rsp2_c = c;
                break;
            end
            if (busy[0]) nbusy++;
            if (cmd_ready[0] && cmd_valid[0] && acc2 < 0) acc2 = c + 1;
            else if (acc2 >= 0 && c >= acc2) cmd_valid[0] = 1'b0;
            @(negedge clk);
            c++;
        end
        cmd_valid[0] = 1'b0;
        check("b2b_second_accept", acc2, 5);
        check("b2b_second_rsp", rsp2_c, 9);
        check("b2b_busy_cycles", nbusy, 8);
        check("b2b_rsp_write", rsp_write[0], 1);

        // Reset while the read strobe is low.
        @(negedge clk);
        cmd_write[0] = 1'b0; cmd_address[0] = 16'h0005; cmd_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_nrd_low", nrd[0], 0);
        nreset = 1'b0;
        #1;
        check("rst_mid_ready", cmd_ready[0], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_mid_nrd_high", nrd[0], 1);
            check("rst_mid_no_rsp", rsp_valid[0], 0);
            check("rst_mid_ready_low", cmd_ready[0], 0);
            check("rst_mid_rdata", rsp_rdata[0], 16'h0000);
        end
        nreset = 1'b1;
        #1;
        check("rst_release_ready", cmd_ready[0], 1);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_release_no_rsp", rsp_valid[0], 0);
        end

`ifdef BUS_WAIT_EN
        run_cmd(0, 1'b0, 16'h0003, 16'h0000, 3, lat, lows, fl, rd, rw);
        check("wait_latency", lat, 7);
        check("wait_nrd_low_cycles", lows, 5);
        check("wait_rdata", rd, 16'hA55A);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
